// File: rtl/snake_pkg.sv
// Shared snake-game types: game mode, direction and the step scheduler state encoding.
// Also holds a helper that sizes the step timeout counter.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    GAME      = 2'd1,
    GAME_OVER = 2'd2
  } game_mode;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    MOVE    = 3'd3,
    COLL    = 3'd4,
    GEN     = 3'd5,
    ERROR   = 3'd6
  } sched_state_e;

  localparam direction SCHED_DIR_INIT = DIR_RIGHT;

  // One counter serves both the peer wait and the stage waits, so size it for the larger limit.
  function automatic int unsigned sched_timer_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/step_timeout_timer.sv
// Cycle counter that flags when it reaches a limit; cleared on demand and never wraps.
module step_timeout_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == limit);

endmodule

// File: rtl/step_scheduler.sv
// Sequences one game step per tick: direction exchange, then move, collisions, point generation.
// Optional tick-overrun statistics are built when STEP_SCHED_STATS_EN is defined.
module step_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT    = 1_500_000,
  parameter int unsigned STAGE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  game_mode   mode,
  input  logic       tick,
  input  direction   dir_local,
  input  direction   dir_remote,
  input  logic       rcvdir,
  output logic       send_dir,
  output logic       move_start,
  input  logic       move_done,
  output logic       coll_start,
  input  logic       coll_done,
  output logic       gen_start,
  input  logic       gen_done,
  output direction   dir1,
  output direction   dir2,
  output logic       busy,
  output logic       con_error,
  output logic [7:0] overruns
);

  localparam int unsigned TW = sched_timer_width(RX_TIMEOUT, STAGE_TIMEOUT);

  sched_state_e state_q, state_d;
  logic         entry_q;
  logic         rx_flag_q;
  direction     dir1_q, dir2_q;
  logic         in_game;
  logic         in_stage;
  logic         timed;
  logic         expired;
  logic [TW-1:0] limit;

  assign in_game  = (mode == GAME);
  assign in_stage = state_q inside {MOVE, COLL, GEN};
  assign timed    = (state_q == WAIT_RX) || in_stage;
  assign limit    = (state_q == WAIT_RX) ? TW'(RX_TIMEOUT - 1) : TW'(STAGE_TIMEOUT - 1);

  assign busy       = (state_q != IDLE) && (state_q != ERROR);
  assign send_dir   = (state_q == SEND);
  assign move_start = entry_q && (state_q == MOVE);
  assign coll_start = entry_q && (state_q == COLL);
  assign gen_start  = entry_q && (state_q == GEN);
  assign con_error  = (state_q == ERROR);
  assign dir1       = dir1_q;
  assign dir2       = dir2_q;

  // Stage done inputs are ignored in the entry cycle, where they would coincide with start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick && in_game) state_d = SEND;
      SEND:    state_d = WAIT_RX;
      WAIT_RX: begin
        if (rx_flag_q)    state_d = MOVE;
        else if (expired) state_d = ERROR;
      end
      MOVE: begin
        if (!entry_q && move_done) state_d = COLL;
        else if (expired)          state_d = ERROR;
      end
      COLL: begin
        if (!entry_q && coll_done) state_d = GEN;
        else if (expired)          state_d = ERROR;
      end
      GEN: begin
        if (!entry_q && gen_done) state_d = IDLE;
        else if (expired)         state_d = ERROR;
      end
      ERROR:   if (!in_game) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (busy && !in_game) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      entry_q   <= 1'b0;
      rx_flag_q <= 1'b0;
      dir1_q    <= SCHED_DIR_INIT;
      dir2_q    <= SCHED_DIR_INIT;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      if ((state_q == IDLE) && (state_d == SEND)) dir1_q <= dir_local;
      // A set in the same cycle as the clear wins: the peer may already be a step ahead.
      if (!in_game) begin
        rx_flag_q <= 1'b0;
      end else if (rcvdir) begin
        rx_flag_q <= 1'b1;
      end else if ((state_q == WAIT_RX) && (state_d == MOVE)) begin
        rx_flag_q <= 1'b0;
      end
      if (in_game && rcvdir && !in_stage) dir2_q <= dir_remote;
    end
  end

  step_timeout_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (timed),
    .limit   (limit),
    .expired (expired)
  );

`ifdef STEP_SCHED_STATS_EN
  game_mode   mode_q;
  logic [7:0] overruns_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MENU;
      overruns_q <= 8'd0;
    end else begin
      mode_q <= mode;
      if (in_game && (mode_q != GAME)) begin
        overruns_q <= 8'd0;
      end else if (tick && busy && in_game && (overruns_q != 8'hff)) begin
        overruns_q <= overruns_q + 8'd1;
      end
    end
  end

  assign overruns = overruns_q;
`else
  assign overruns = 8'd0;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: full step, early peer, peer and stage timeouts,
// dropped ticks and aborts in COLL. Honours STEP_SCHED_STATS_EN for the overrun count.
module tb_step_scheduler;
  import snake_pkg::*;

  localparam int unsigned RX_T  = 20;
  localparam int unsigned STG_T = 1024;

  logic       clk = 1'b0;
  logic       rst;
  game_mode   mode;
  logic       tick;
  direction   dir_local, dir_remote;
  logic       rcvdir;
  logic       send_dir;
  logic       move_start, move_done;
  logic       coll_start, coll_done;
  logic       gen_start, gen_done;
  direction   dir1, dir2;
  logic       busy, con_error;
  logic [7:0] overruns;

  step_scheduler #(
    .RX_TIMEOUT    (RX_T),
    .STAGE_TIMEOUT (STG_T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .tick       (tick),
    .dir_local  (dir_local),
    .dir_remote (dir_remote),
    .rcvdir     (rcvdir),
    .send_dir   (send_dir),
    .move_start (move_start),
    .move_done  (move_done),
    .coll_start (coll_start),
    .coll_done  (coll_done),
    .gen_start  (gen_start),
    .gen_done   (gen_done),
    .dir1       (dir1),
    .dir2       (dir2),
    .busy       (busy),
    .con_error  (con_error),
    .overruns   (overruns)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_send, n_move, n_coll, n_gen;
  int t_send, t_move, t_coll, t_gen, t_err, t_idle;
  int rx_delay;
  bit auto_done, hold_coll, prev_busy;
  bit pend_move, pend_coll, pend_gen;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    n_send = 0; n_move = 0; n_coll = 0; n_gen = 0;
    t_send = -1; t_move = -1; t_coll = -1; t_gen = -1; t_err = -1; t_idle = -1;
    pend_move = 0; pend_coll = 0; pend_gen = 0;
  endtask

  // Advance n cycles, log events and answer each start with done one cycle later.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      tick   = 1'b0;
      rcvdir = 1'b0;
      if (send_dir)   begin n_send++; t_send = cyc; end
      if (move_start) begin n_move++; t_move = cyc; end
      if (coll_start) begin n_coll++; t_coll = cyc; end
      if (gen_start)  begin n_gen++;  t_gen  = cyc; end
      if (con_error && (t_err < 0)) t_err = cyc;
      if (!busy && prev_busy) t_idle = cyc;
      prev_busy = busy;
      move_done = auto_done && pend_move;
      coll_done = auto_done && !hold_coll && pend_coll;
      gen_done  = auto_done && pend_gen;
      pend_move = move_start;
      pend_coll = coll_start;
      pend_gen  = gen_start;
      rcvdir = (rx_delay >= 0) && (t_send >= 0) && (cyc == t_send + rx_delay);
    end
  endtask

  task automatic test_reset();
    clear_log();
    rst = 1'b1;
    mode = MENU;
    run(3);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_tests++; if (con_error !== 1'b0) begin n_fail++; $display("FAIL reset_con_error: got %0b expected 0", con_error); end
    n_tests++; if ({send_dir, move_start, coll_start, gen_start} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {send_dir, move_start, coll_start, gen_start}); end
    n_tests++; if (dir1 !== SCHED_DIR_INIT) begin n_fail++; $display("FAIL reset_dir1: got %0d expected %0d", dir1, SCHED_DIR_INIT); end
    n_tests++; if (dir2 !== SCHED_DIR_INIT) begin n_fail++; $display("FAIL reset_dir2: got %0d expected %0d", dir2, SCHED_DIR_INIT); end
    n_tests++; if (overruns !== 8'd0) begin n_fail++; $display("FAIL reset_overruns: got %0d expected 0", overruns); end
    rst = 1'b0;
    tick = 1'b1;
    run(3);
    n_tests++; if (n_send !== 0) begin n_fail++; $display("FAIL tick_outside_game: got %0d send_dir expected 0", n_send); end
    mode = GAME;
    run(1);
  endtask

  task automatic test_full_step();
    int t0;
    clear_log();
    rx_delay = 2;
    dir_local = DIR_UP;
    dir_remote = DIR_LEFT;
    t0 = cyc;
    tick = 1'b1;
    run(14);
    n_tests++; if (n_send !== 1) begin n_fail++; $display("FAIL step_send_count: got %0d expected 1", n_send); end
    n_tests++; if (t_send - t0 !== 1) begin n_fail++; $display("FAIL step_send_time: got %0d expected 1", t_send - t0); end
    n_tests++; if (t_move - t0 !== 5) begin n_fail++; $display("FAIL step_move_time: got %0d expected 5", t_move - t0); end
    n_tests++; if (t_coll - t0 !== 7) begin n_fail++; $display("FAIL step_coll_time: got %0d expected 7", t_coll - t0); end
    n_tests++; if (t_gen - t0 !== 9) begin n_fail++; $display("FAIL step_gen_time: got %0d expected 9", t_gen - t0); end
    n_tests++; if (t_idle - t0 !== 11) begin n_fail++; $display("FAIL step_busy_fall: got %0d expected 11", t_idle - t0); end
    n_tests++; if ({n_move, n_coll, n_gen} !== {32'd1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL step_start_counts: got %0d/%0d/%0d expected 1/1/1", n_move, n_coll, n_gen); end
    n_tests++; if (dir1 !== DIR_UP) begin n_fail++; $display("FAIL step_dir1: got %0d expected %0d", dir1, DIR_UP); end
    n_tests++; if (dir2 !== DIR_LEFT) begin n_fail++; $display("FAIL step_dir2: got %0d expected %0d", dir2, DIR_LEFT); end
  endtask

  task automatic test_early_peer();
    int t0;
    clear_log();
    rx_delay = -1;
    dir_remote = DIR_DOWN;
    rcvdir = 1'b1;
    run(2);
    dir_local = DIR_LEFT;
    t0 = cyc;
    tick = 1'b1;
    run(12);
    n_tests++; if (t_move - t0 !== 3) begin n_fail++; $display("FAIL early_tick_to_move: got %0d expected 3", t_move - t0); end
    n_tests++; if (n_move !== 1) begin n_fail++; $display("FAIL early_move_count: got %0d expected 1", n_move); end
    n_tests++; if (dir1 !== DIR_LEFT) begin n_fail++; $display("FAIL early_dir1: got %0d expected %0d", dir1, DIR_LEFT); end
    n_tests++; if (dir2 !== DIR_DOWN) begin n_fail++; $display("FAIL early_dir2: got %0d expected %0d", dir2, DIR_DOWN); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: got busy %0b expected 0", busy); end
  endtask

  task automatic test_rx_timeout();
    int t0;
    clear_log();
    rx_delay = -1;
    t0 = cyc;
    tick = 1'b1;
    run(RX_T + 6);
    n_tests++; if (t_err - t0 !== 2 + RX_T) begin n_fail++; $display("FAIL rx_timeout_time: got %0d expected %0d", t_err - t0, 2 + RX_T); end
    n_tests++; if (n_move !== 0) begin n_fail++; $display("FAIL rx_timeout_no_move: got %0d expected 0", n_move); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_timeout_busy: got %0b expected 0", busy); end
    mode = MENU;
    run(1);
    n_tests++; if (con_error !== 1'b0) begin n_fail++; $display("FAIL rx_error_clear: got %0b expected 0", con_error); end
  endtask

  task automatic test_stage_timeout();
    int t0;
    mode = GAME;
    run(1);
    clear_log();
    rx_delay = 2;
    hold_coll = 1'b1;
    t0 = cyc;
    tick = 1'b1;
    run(STG_T + 15);
    n_tests++; if (t_coll - t0 !== 7) begin n_fail++; $display("FAIL stage_coll_time: got %0d expected 7", t_coll - t0); end
    n_tests++; if (t_err - t_coll !== STG_T) begin n_fail++; $display("FAIL stage_timeout_time: got %0d expected %0d", t_err - t_coll, STG_T); end
    n_tests++; if (n_gen !== 0) begin n_fail++; $display("FAIL stage_no_gen: got %0d expected 0", n_gen); end
    n_tests++; if (con_error !== 1'b1) begin n_fail++; $display("FAIL stage_error_sticky: got %0b expected 1", con_error); end
    hold_coll = 1'b0;
    mode = MENU;
    run(1);
    n_tests++; if (con_error !== 1'b0) begin n_fail++; $display("FAIL stage_error_clear: got %0b expected 0", con_error); end
  endtask

  task automatic test_overruns();
    logic [7:0] exp_ovr;
`ifdef STEP_SCHED_STATS_EN
    exp_ovr = 8'd3;
`else
    exp_ovr = 8'd0;
`endif
    mode = GAME;
    run(1);
    clear_log();
    rx_delay = 2;
    tick = 1'b1; run(2);
    tick = 1'b1; run(2);
    tick = 1'b1; run(2);
    tick = 1'b1; run(12);
    n_tests++; if (n_send !== 1) begin n_fail++; $display("FAIL overrun_single_step: got %0d send_dir expected 1", n_send); end
    n_tests++; if (n_gen !== 1) begin n_fail++; $display("FAIL overrun_gen_count: got %0d expected 1", n_gen); end
    n_tests++; if (overruns !== exp_ovr) begin n_fail++; $display("FAIL overrun_count: got %0d expected %0d", overruns, exp_ovr); end
  endtask

  task automatic test_abort_in_coll();
    int t0;
    // Reset while in COLL.
    clear_log();
    rx_delay = 2;
    t0 = cyc;
    tick = 1'b1;
    run(7);
    n_tests++; if (t_coll - t0 !== 7) begin n_fail++; $display("FAIL rst_reach_coll: got %0d expected 7", t_coll - t0); end
    rst = 1'b1;
    run(1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_coll_busy: got %0b expected 0", busy); end
    n_tests++; if (dir1 !== SCHED_DIR_INIT || dir2 !== SCHED_DIR_INIT) begin n_fail++; $display("FAIL rst_coll_dirs: got %0d/%0d expected %0d/%0d", dir1, dir2, SCHED_DIR_INIT, SCHED_DIR_INIT); end
    n_tests++; if (overruns !== 8'd0) begin n_fail++; $display("FAIL rst_coll_overruns: got %0d expected 0", overruns); end
    rst = 1'b0;
    run(5);
    n_tests++; if (n_gen !== 0) begin n_fail++; $display("FAIL rst_coll_no_gen: got %0d expected 0", n_gen); end
    // Leave GAME while in COLL.
    clear_log();
    dir_local = DIR_DOWN;
    dir_remote = DIR_UP;
    t0 = cyc;
    tick = 1'b1;
    run(7);
    mode = MENU;
    run(1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL menu_coll_busy: got %0b expected 0", busy); end
    n_tests++; if (dir1 !== DIR_DOWN || dir2 !== DIR_UP) begin n_fail++; $display("FAIL menu_coll_dirs: got %0d/%0d expected %0d/%0d", dir1, dir2, DIR_DOWN, DIR_UP); end
    run(5);
    n_tests++; if (n_gen !== 0) begin n_fail++; $display("FAIL menu_coll_no_gen: got %0d expected 0", n_gen); end
    n_tests++; if (con_error !== 1'b0) begin n_fail++; $display("FAIL menu_coll_con_error: got %0b expected 0", con_error); end
  endtask

  initial begin
    rst = 1'b1; mode = MENU; tick = 1'b0; rcvdir = 1'b0;
    dir_local = DIR_UP; dir_remote = DIR_UP;
    move_done = 1'b0; coll_done = 1'b0; gen_done = 1'b0;
    rx_delay = -1; auto_done = 1'b1; hold_coll = 1'b0; prev_busy = 1'b0;
    clear_log();
    test_reset();
    test_full_step();
    test_early_peer();
    test_rx_timeout();
    test_stage_timeout();
    test_overruns();
    test_abort_in_coll();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
